// File: rtl/alu_result_capture.sv
// Registers the ALU result/flags and counts valid results over a measurement window.
// Optional signature register is built only when ALU_RESULT_MISR_EN is defined.
module alu_result_capture #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       WINDOW    = 16,
  parameter logic [WIDTH-1:0]  MISR_POLY = WIDTH'(32'h04C11DB7)
) (
  input  logic                       clk_i,
  input  logic                       async_reset_i,
  input  logic [WIDTH-1:0]           result_i,
  input  logic                       carry_i,
  input  logic                       valid_i,
  input  logic                       start_i,
  output logic [WIDTH-1:0]           result_o,
  output logic                       carry_o,
  output logic                       zero_o,
  output logic                       neg_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(WINDOW+1)-1:0] count_o,
  output logic [WIDTH-1:0]           signature_o
);

  localparam int unsigned     CW   = $clog2(WINDOW + 1);
  localparam logic [CW-1:0]   LAST = CW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t state, state_next;
  logic   open_window;
  logic   sample;

  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i) begin
      result_o <= '0;
      carry_o  <= 1'b0;
      zero_o   <= 1'b0;
      neg_o    <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      result_o <= result_i;
      carry_o  <= carry_i;
      zero_o   <= (result_i == '0);
      neg_o    <= result_i[WIDTH-1];
      valid_o  <= valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = COUNT;
      COUNT:   if (valid_o && (count_o == LAST)) state_next = DONE;
      DONE:    if (start_i) state_next = COUNT;
      default: state_next = IDLE;
    endcase
  end

  // The accumulator only sees registered samples, never result_i.
  assign open_window = (state != COUNT) && start_i;
  assign sample      = (state == COUNT) && valid_o;
  assign busy_o      = (state == COUNT);
  assign done_o      = (state == DONE);

  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i)   count_o <= '0;
    else if (open_window) count_o <= '0;
    else if (sample)      count_o <= count_o + CW'(1);
  end

`ifdef ALU_RESULT_MISR_EN
  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i)   signature_o <= '0;
    else if (open_window) signature_o <= '0;
    else if (sample)
      signature_o <= (signature_o << 1)
                   ^ (signature_o[WIDTH-1] ? MISR_POLY : '0)
                   ^ result_o;
  end
`else
  // Tied off; the polynomial stays referenced so both builds share one parameter list.
  assign signature_o = MISR_POLY & {WIDTH{1'b0}};
`endif

endmodule
